hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard controller next to the forwarding unit. Computes PC/IF_ID hold, ID_EX bubble and IF_ID flush.

---
 rtl/hazard_stall_ctrl_pkg.sv | 33 +++
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl_muldiv_timer.sv | 48 ++++
 rtl/hazard_stall_ctrl.sv | 71 +++++++
 tb/tb_hazard_stall_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - MIPS opcode/funct constants and decode helpers
// Package mips_defs: shared opcode/funct localparams and small decode
// functions used by the hazard controller and its mult/div timer.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) &&
           (fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
  endfunction

  function automatic logic is_jr(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_JR || fn == FN_JALR);
  endfunction

  // Any instruction touching HI/LO must wait for the unit to drain.
  function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) &&
           (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-side bundle for the hazard controller
// master: pipeline driving ID/EX/MEM fields, receiving hold/flush controls.
// slave:  hazard_stall_ctrl consuming fields, driving controls.
interface hazard_stall_ctrl_if;
  logic [5:0]  IF_ID_Opcode;
  logic [5:0]  IF_ID_Function;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        IF_ID_Uses_Rt;
  logic        ID_EX_MemRead;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_Write_Address;
  logic [5:0]  ID_EX_Opcode;
  logic [5:0]  ID_EX_Function;
  logic        EX_MEM_MemRead;
  logic [4:0]  EX_MEM_Write_Address;
  logic        Branch_Taken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Flush;
  logic        IF_ID_Flush;
  logic        MulDiv_Start;
  logic        MulDiv_Busy;
  logic [31:0] Stall_Count;

  modport master (
    output IF_ID_Opcode, IF_ID_Function, IF_ID_Rs, IF_ID_Rt, IF_ID_Uses_Rt,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_Address, ID_EX_Opcode,
           ID_EX_Function, EX_MEM_MemRead, EX_MEM_Write_Address, Branch_Taken,
    input  PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, MulDiv_Start,
           MulDiv_Busy, Stall_Count
  );

  modport slave (
    input  IF_ID_Opcode, IF_ID_Function, IF_ID_Rs, IF_ID_Rt, IF_ID_Uses_Rt,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Write_Address, ID_EX_Opcode,
           ID_EX_Function, EX_MEM_MemRead, EX_MEM_Write_Address, Branch_Taken,
    output PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, MulDiv_Start,
           MulDiv_Busy, Stall_Count
  );
endinterface

// File: rtl/hazard_stall_ctrl_muldiv_timer.sv
// rtl/hazard_stall_ctrl_muldiv_timer.sv - occupancy timer of the HI/LO mult/div unit
// Ports: clk, reset (sync active-low), i_ex_opcode/i_ex_funct (instruction in EX),
//        o_start (mult/div entering the unit now), o_busy (cnt != 0).
module muldiv_timer
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_ex_opcode,
  input  logic [5:0] i_ex_funct,
  output logic       o_start,
  output logic       o_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [3:0] r_cnt;
  logic       w_is_div;

  assign o_start  = is_muldiv(i_ex_opcode, i_ex_funct);
  assign w_is_div = (i_ex_funct == FN_DIV) || (i_ex_funct == FN_DIVU);
  assign o_busy   = (r_cnt != 4'd0);

  // The start cycle itself counts as the first occupied cycle, so only
  // N-1 further cycles are loaded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (o_start) begin
      r_cnt <= w_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ID stalls new mult/div ops while busy, so a start over a running op
  // means the surrounding pipeline ignored the stall.
  always_ff @(posedge clk) begin
    if (reset && o_start) begin
      assert (r_cnt == 4'd0);
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / jr / HI-LO hazard stall and flush control
// Ports: clk, reset (sync active-low), bus (hazard_stall_ctrl_if.slave):
//   ID/EX/MEM instruction fields and Branch_Taken in; PC_Write, IF_ID_Write,
//   ID_EX_Flush, IF_ID_Flush, MulDiv_Start, MulDiv_Busy, Stall_Count out.
module hazard_stall_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 12
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic        w_load_use;
  logic        w_jr_haz;
  logic        w_md_haz;
  logic        w_stall;
  logic        w_start;
  logic        w_busy;
  logic [31:0] r_stall_count;

  muldiv_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_ex_opcode (bus.ID_EX_Opcode),
    .i_ex_funct  (bus.ID_EX_Function),
    .o_start     (w_start),
    .o_busy      (w_busy)
  );

  assign w_load_use = bus.ID_EX_MemRead && (bus.ID_EX_Write_Address != 5'd0) &&
                      ((bus.ID_EX_Write_Address == bus.IF_ID_Rs) ||
                       (bus.IF_ID_Uses_Rt && bus.ID_EX_Write_Address == bus.IF_ID_Rt));

  // A non-load in MEM reaches ID through forwarding; only a load in MEM or
  // any writer in EX is too late for the jump target read.
  assign w_jr_haz = is_jr(bus.IF_ID_Opcode, bus.IF_ID_Function) &&
                    (bus.IF_ID_Rs != 5'd0) &&
                    ((bus.ID_EX_RegWrite && bus.ID_EX_Write_Address == bus.IF_ID_Rs) ||
                     (bus.EX_MEM_MemRead && bus.EX_MEM_Write_Address == bus.IF_ID_Rs));

  assign w_md_haz = (is_hilo(bus.IF_ID_Opcode, bus.IF_ID_Function) ||
                     is_muldiv(bus.IF_ID_Opcode, bus.IF_ID_Function)) &&
                    (w_busy || w_start);

  assign w_stall = w_load_use || w_jr_haz || w_md_haz;

  assign bus.PC_Write     = !w_stall;
  assign bus.IF_ID_Write  = !w_stall;
  assign bus.ID_EX_Flush  = w_stall;
  // A stalled branch re-resolves after the stall, so squashing now would
  // drop the fall-through instruction twice.
  assign bus.IF_ID_Flush  = bus.Branch_Taken && !w_stall;
  assign bus.MulDiv_Start = w_start;
  assign bus.MulDiv_Busy  = w_busy;
  assign bus.Stall_Count  = r_stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_count <= 32'd0;
    end else if (w_stall && r_stall_count != 32'hFFFF_FFFF) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam int MC = 4;
  localparam int DC = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: occupied cycles still remaining, and stall tally.
  int     m_rem = 0;
  longint m_cnt = 0;

  function automatic bit f_md(input logic [5:0] op, input logic [5:0] f);
    return op == 0 && (f == 6'h18 || f == 6'h19 || f == 6'h1A || f == 6'h1B);
  endfunction

  function automatic bit f_stall();
    bit lu, jh, mh, jr, hl;
    lu = bus.ID_EX_MemRead && bus.ID_EX_Write_Address != 0 &&
         (bus.ID_EX_Write_Address == bus.IF_ID_Rs ||
          (bus.IF_ID_Uses_Rt && bus.ID_EX_Write_Address == bus.IF_ID_Rt));
    jr = bus.IF_ID_Opcode == 0 && (bus.IF_ID_Function == 6'h08 || bus.IF_ID_Function == 6'h09);
    jh = jr && bus.IF_ID_Rs != 0 &&
         ((bus.ID_EX_RegWrite && bus.ID_EX_Write_Address == bus.IF_ID_Rs) ||
          (bus.EX_MEM_MemRead && bus.EX_MEM_Write_Address == bus.IF_ID_Rs));
    hl = bus.IF_ID_Opcode == 0 && bus.IF_ID_Function >= 6'h10 && bus.IF_ID_Function <= 6'h13;
    mh = (hl || f_md(bus.IF_ID_Opcode, bus.IF_ID_Function)) &&
         (m_rem > 0 || f_md(bus.ID_EX_Opcode, bus.ID_EX_Function));
    return lu || jh || mh;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.IF_ID_Opcode = 6'h08; bus.IF_ID_Function = 6'h20;
    bus.IF_ID_Rs = 0; bus.IF_ID_Rt = 0; bus.IF_ID_Uses_Rt = 0;
    bus.ID_EX_MemRead = 0; bus.ID_EX_RegWrite = 0; bus.ID_EX_Write_Address = 0;
    bus.ID_EX_Opcode = 6'h08; bus.ID_EX_Function = 6'h20;
    bus.EX_MEM_MemRead = 0; bus.EX_MEM_Write_Address = 0; bus.Branch_Taken = 0;
  endtask

  // Compare all outputs with the model mid-cycle, then advance the model
  // across the next rising edge using the inputs held during this cycle.
  task automatic cycle(input string tag);
    bit st, md;
    @(negedge clk);
    st = f_stall();
    md = f_md(bus.ID_EX_Opcode, bus.ID_EX_Function);
    chk({tag, ":pc"}, {31'd0, bus.PC_Write}, {31'd0, !st});
    chk({tag, ":ifw"}, {31'd0, bus.IF_ID_Write}, {31'd0, !st});
    chk({tag, ":exfl"}, {31'd0, bus.ID_EX_Flush}, {31'd0, st});
    chk({tag, ":iffl"}, {31'd0, bus.IF_ID_Flush}, {31'd0, bus.Branch_Taken && !st});
    chk({tag, ":start"}, {31'd0, bus.MulDiv_Start}, {31'd0, md});
    chk({tag, ":busy"}, {31'd0, bus.MulDiv_Busy}, {31'd0, m_rem > 0});
    chk({tag, ":scnt"}, bus.Stall_Count, m_cnt[31:0]);
    @(posedge clk);
    if (!reset) begin
      m_rem = 0; m_cnt = 0;
    end else begin
      if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (md) m_rem = (bus.ID_EX_Function >= 6'h1A) ? DC - 1 : MC - 1;
      else if (m_rem > 0) m_rem--;
    end
    #1;
  endtask

  int n, b;

  initial begin
    idle();
    reset = 0;
    cycle("rst");
    reset = 1;
    #1;
    chk("rst_scnt", bus.Stall_Count, 32'd0);
    chk("rst_busy", {31'd0, bus.MulDiv_Busy}, 32'd0);

    // 1: lw $2 in EX, add $3,$2,$4 in ID
    idle();
    bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_Write_Address = 2;
    bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h20;
    bus.IF_ID_Rs = 2; bus.IF_ID_Rt = 4; bus.IF_ID_Uses_Rt = 1;
    #1;
    chk("s1_pc0", {31'd0, bus.PC_Write}, 32'd0);
    cycle("s1");
    chk("s1_cnt1", bus.Stall_Count, 32'd1);
    idle();
    cycle("s1b");

    // 2: jr $31 with lw $31 in EX, then in MEM, then gone
    n = 0;
    for (int s = 0; s < 3; s++) begin
      idle();
      bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h08; bus.IF_ID_Rs = 31;
      if (s == 0) begin
        bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_Write_Address = 31;
      end else if (s == 1) begin
        bus.EX_MEM_MemRead = 1; bus.EX_MEM_Write_Address = 31;
      end
      #1;
      if (!bus.PC_Write) n++;
      cycle("s2");
    end
    chk("s2_lw_stalls", n, 2);
    idle();
    bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h09; bus.IF_ID_Rs = 31;
    bus.ID_EX_RegWrite = 1; bus.ID_EX_Write_Address = 31;
    cycle("s2_addi");
    bus.ID_EX_RegWrite = 0; bus.ID_EX_Write_Address = 0;
    bus.EX_MEM_Write_Address = 31;
    #1;
    chk("s2_fwd_nostall", {31'd0, bus.PC_Write}, 32'd1);
    cycle("s2_fwd");

    // 3: mult in EX, mflo held in ID until the unit drains
    idle();
    bus.ID_EX_Opcode = 0; bus.ID_EX_Function = 6'h18;
    bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h12;
    n = 0; b = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.PC_Write) break;
      n++;
      if (bus.MulDiv_Busy) b++;
      cycle("s3");
      bus.ID_EX_Opcode = 6'h08; bus.ID_EX_Function = 6'h20;
    end
    chk("s3_stalls", n, MC);
    chk("s3_busy", b, MC - 1);
    cycle("s3_issue");

    // 4: div then div back-to-back
    idle();
    bus.ID_EX_Opcode = 0; bus.ID_EX_Function = 6'h1A;
    bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h1A;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.PC_Write) break;
      n++;
      cycle("s4");
      bus.ID_EX_Opcode = 6'h08; bus.ID_EX_Function = 6'h20;
    end
    chk("s4_held", n, DC);
    cycle("s4_issue");
    idle();
    bus.ID_EX_Opcode = 0; bus.ID_EX_Function = 6'h1B;
    #1;
    chk("s4_start", {31'd0, bus.MulDiv_Start}, 32'd1);
    cycle("s4_start");
    idle();
    b = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus.MulDiv_Busy) break;
      b++;
      cycle("s4_busy");
    end
    chk("s4_cnt11", b, DC - 1);

    // 5: branch vs load_use
    idle();
    bus.Branch_Taken = 1;
    bus.ID_EX_MemRead = 1; bus.ID_EX_Write_Address = 5; bus.IF_ID_Rs = 5;
    #1;
    chk("s5_noflush", {31'd0, bus.IF_ID_Flush}, 32'd0);
    cycle("s5a");
    bus.ID_EX_MemRead = 0;
    #1;
    chk("s5_flush", {31'd0, bus.IF_ID_Flush}, 32'd1);
    cycle("s5b");

    // 6: reset mid-divide, and $0 never stalls
    idle();
    bus.ID_EX_Opcode = 0; bus.ID_EX_Function = 6'h1A;
    cycle("s6_start");
    idle();
    for (int i = 0; i < 4; i++) cycle("s6_run");
    reset = 0;
    cycle("s6_rst");
    reset = 1;
    #1;
    chk("s6_busy", {31'd0, bus.MulDiv_Busy}, 32'd0);
    chk("s6_scnt", bus.Stall_Count, 32'd0);
    bus.ID_EX_MemRead = 1; bus.ID_EX_RegWrite = 1; bus.ID_EX_Write_Address = 0;
    bus.IF_ID_Opcode = 0; bus.IF_ID_Function = 6'h08; bus.IF_ID_Rs = 0;
    bus.EX_MEM_MemRead = 1; bus.EX_MEM_Write_Address = 0;
    #1;
    chk("s6_r0", {31'd0, bus.PC_Write}, 32'd1);
    cycle("s6_r0");

    // Random traffic; mult/div enter EX only once the unit is idle.
    for (int i = 0; i < 400; i++) begin
      logic [5:0] fl [9];
      fl = '{6'h08, 6'h09, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20};
      reset = ($urandom_range(0, 49) != 0);
      bus.IF_ID_Opcode = ($urandom_range(0, 3) == 0) ? 6'h23 : 6'h00;
      bus.IF_ID_Function = fl[$urandom_range(0, 8)];
      bus.IF_ID_Rs = 5'($urandom_range(0, 3));
      bus.IF_ID_Rt = 5'($urandom_range(0, 3));
      bus.IF_ID_Uses_Rt = 1'($urandom);
      bus.ID_EX_MemRead = 1'($urandom);
      bus.ID_EX_RegWrite = 1'($urandom);
      bus.ID_EX_Write_Address = 5'($urandom_range(0, 3));
      bus.ID_EX_Opcode = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'h08;
      bus.ID_EX_Function = fl[$urandom_range(0, 8)];
      if (m_rem > 0 && f_md(bus.ID_EX_Opcode, bus.ID_EX_Function))
        bus.ID_EX_Function = 6'h20;
      bus.EX_MEM_MemRead = 1'($urandom);
      bus.EX_MEM_Write_Address = 5'($urandom_range(0, 3));
      bus.Branch_Taken = 1'($urandom);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
